pwm_deadtime: RTL and testbench

Complementary-output stage directly downstream of the SoC timer. Consumes the timer's three PWM compare lines and drives a high-side/low-side gate pair per channel. Programmable dead time guarantees both sides of a pair are never on together. Includes a latched fault shutdown and registers on the Wishbone peripheral bus.

---
 rtl/pwm_deadtime_pkg.sv | 35 +++
 rtl/wb_bus.sv | 30 +++
 rtl/pwm_deadtime_channel.sv | 99 +++++++++
 rtl/pwm_deadtime.sv | 135 +++++++++++++
 tb/tb_pwm_deadtime.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_deadtime_pkg.sv
// ============================================================================
// Module   : pwm_deadtime_pkg
// Brief    : Shared types and constants for the complementary PWM dead-time stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_deadtime_pkg;

    localparam int c_num_ch = 3;
    localparam int c_cnt_w  = 16;

    localparam logic [31:0] c_ofs_control  = 32'h0;
    localparam logic [31:0] c_ofs_deadtime = 32'h4;
    localparam logic [31:0] c_ofs_status   = 32'h8;

    localparam int c_ctrl_en_bit        = 0;
    localparam int c_ctrl_ch_en_lsb     = 1;
    localparam int c_ctrl_fault_clr_bit = 4;

    localparam int c_stat_hi_lsb    = 0;
    localparam int c_stat_lo_lsb    = 3;
    localparam int c_stat_fault_bit = 8;

    typedef enum logic [4:0] {
        S_IDLE       = 5'b00001,
        S_DEAD_TO_HI = 5'b00010,
        S_HI_ON      = 5'b00100,
        S_DEAD_TO_LO = 5'b01000,
        S_LO_ON      = 5'b10000
    } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_bus.sv
// ============================================================================
// Module   : wb_bus
// Brief    : Classic Wishbone peripheral bus bundle (32-bit data, byte selects)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_bus;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [31:0] dat_s2m;
    logic [3:0]  sel;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, dat_m2s, sel,
        input  dat_s2m, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m2s, sel,
        output dat_s2m, ack, err
    );
endinterface

`default_nettype wire

// File: rtl/pwm_deadtime_channel.sv
// ============================================================================
// Module   : pwm_deadtime_channel
// Brief    : One complementary gate pair: one-hot FSM plus 16-bit dead counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_deadtime_channel
    import pwm_deadtime_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               active,
    input  logic               pwm_in,
    input  logic [c_cnt_w-1:0] dt_hi,
    input  logic [c_cnt_w-1:0] dt_lo,
    output logic               pwm_hi_out,
    output logic               pwm_lo_out
);

    ch_state_t          r_state;
    ch_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A reversal of pwm_in during a dead window jumps straight to the side
    // that was already off long enough, so no second dead window is added.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!active) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pwm_in) begin
                        w_state_nxt = S_DEAD_TO_HI;
                        w_cnt_nxt   = dt_hi;
                    end else begin
                        w_state_nxt = S_DEAD_TO_LO;
                        w_cnt_nxt   = dt_lo;
                    end
                end
                S_DEAD_TO_HI: begin
                    if (!pwm_in) begin
                        w_state_nxt = S_LO_ON;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = S_HI_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_w'(1);
                    end
                end
                S_DEAD_TO_LO: begin
                    if (pwm_in) begin
                        w_state_nxt = S_HI_ON;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = S_LO_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_w'(1);
                    end
                end
                S_HI_ON: begin
                    if (!pwm_in) begin
                        w_state_nxt = S_DEAD_TO_LO;
                        w_cnt_nxt   = dt_lo;
                    end
                end
                S_LO_ON: begin
                    if (pwm_in) begin
                        w_state_nxt = S_DEAD_TO_HI;
                        w_cnt_nxt   = dt_hi;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign pwm_hi_out = (r_state == S_HI_ON);
    assign pwm_lo_out = (r_state == S_LO_ON);

endmodule

`default_nettype wire

// File: rtl/pwm_deadtime.sv
// ============================================================================
// Module   : pwm_deadtime
// Brief    : 3-channel complementary PWM stage with dead time and Wishbone regs.
//            Define PWM_DEADTIME_FAULT_EN to build the latched fault shutdown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4040
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [c_num_ch-1:0] pwm_in,
    input  logic                fault_in,
    output logic [c_num_ch-1:0] pwm_hi_out,
    output logic [c_num_ch-1:0] pwm_lo_out,
    wb_bus.slave                bus_slave
);

    logic                w_bus_req;
    logic                w_wr;
    logic                w_hit_ctrl;
    logic                w_hit_dt;
    logic                w_hit_stat;
    logic                w_fault_clr;
    logic                w_fault_block;
    logic                w_fault_status;
    logic [c_num_ch:0]   r_control;
    logic [c_cnt_w-1:0]  r_dt_hi;
    logic [c_cnt_w-1:0]  r_dt_lo;
    logic [c_num_ch-1:0] w_ch_active;
    logic [31:0]         w_rdata;

    assign w_bus_req  = bus_slave.cyc & bus_slave.stb;
    assign w_wr       = w_bus_req & bus_slave.we;
    assign w_hit_ctrl = (bus_slave.adr == BASE_ADDR + c_ofs_control);
    assign w_hit_dt   = (bus_slave.adr == BASE_ADDR + c_ofs_deadtime);
    assign w_hit_stat = (bus_slave.adr == BASE_ADDR + c_ofs_status);

    assign w_fault_clr = w_wr & w_hit_ctrl & bus_slave.sel[0]
                       & bus_slave.dat_m2s[c_ctrl_fault_clr_bit];

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_control <= '0;
            r_dt_hi   <= '0;
            r_dt_lo   <= '0;
        end else if (w_wr) begin
            if (w_hit_ctrl && bus_slave.sel[0]) begin
                r_control <= bus_slave.dat_m2s[c_num_ch:0];
            end
            if (w_hit_dt) begin
                if (bus_slave.sel[0]) r_dt_hi[7:0]  <= bus_slave.dat_m2s[7:0];
                if (bus_slave.sel[1]) r_dt_hi[15:8] <= bus_slave.dat_m2s[15:8];
                if (bus_slave.sel[2]) r_dt_lo[7:0]  <= bus_slave.dat_m2s[23:16];
                if (bus_slave.sel[3]) r_dt_lo[15:8] <= bus_slave.dat_m2s[31:24];
            end
        end
    end

`ifdef PWM_DEADTIME_FAULT_EN
    logic r_fault_meta;
    logic r_fault_sync;
    logic r_fault_latched;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_fault_meta    <= 1'b0;
            r_fault_sync    <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_fault_meta <= fault_in;
            r_fault_sync <= r_fault_meta;
            if (r_fault_sync) begin
                r_fault_latched <= 1'b1;
            end else if (w_fault_clr) begin
                r_fault_latched <= 1'b0;
            end
        end
    end

    // Blocking on the synchronized level as well as the latch saves one edge
    // on the shutdown path, keeping it to three edges from the pin.
    assign w_fault_block  = r_fault_sync | r_fault_latched;
    assign w_fault_status = r_fault_latched;
`else
    logic w_unused_fault;

    assign w_unused_fault = fault_in ^ w_fault_clr;
    assign w_fault_block  = 1'b0;
    assign w_fault_status = 1'b0;
`endif

    generate
        for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
            assign w_ch_active[g] = r_control[c_ctrl_en_bit]
                                  & r_control[c_ctrl_ch_en_lsb + g]
                                  & ~w_fault_block;

            pwm_deadtime_channel u_channel (
                .clk_in     (clk_in),
                .reset_in   (reset_in),
                .active     (w_ch_active[g]),
                .pwm_in     (pwm_in[g]),
                .dt_hi      (r_dt_hi),
                .dt_lo      (r_dt_lo),
                .pwm_hi_out (pwm_hi_out[g]),
                .pwm_lo_out (pwm_lo_out[g])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl) begin
            w_rdata[c_num_ch:0] = r_control;
        end else if (w_hit_dt) begin
            w_rdata = {r_dt_lo, r_dt_hi};
        end else if (w_hit_stat) begin
            w_rdata[c_stat_hi_lsb +: c_num_ch] = pwm_hi_out;
            w_rdata[c_stat_lo_lsb +: c_num_ch] = pwm_lo_out;
            w_rdata[c_stat_fault_bit]          = w_fault_status;
        end
    end

    assign bus_slave.dat_s2m = w_rdata;
    assign bus_slave.ack     = w_bus_req;
    assign bus_slave.err     = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_pwm_deadtime.sv
// ============================================================================
// Module   : tb_pwm_deadtime
// Brief    : Self-checking bench for pwm_deadtime with a run-length output model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_deadtime;

    localparam logic [31:0] c_base = 32'h4040;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] pwm;
    logic       fault;
    logic [2:0] hi;
    logic [2:0] lo;

    wb_bus bus ();

    pwm_deadtime dut (
        .clk_in     (clk),
        .reset_in   (rst_n),
        .pwm_in     (pwm),
        .fault_in   (fault),
        .pwm_hi_out (hi),
        .pwm_lo_out (lo),
        .bus_slave  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outputs derived from run lengths of pwm_in per channel
    logic [3:0]  m_ctrl = '0;
    logic [15:0] m_dt_hi = '0;
    logic [15:0] m_dt_lo = '0;
    bit          m_block = 1'b0;
    bit          m_allow_clear = 1'b0;
    int          rh[3];
    int          rl[3];
    int          cap_h[3];
    int          cap_l[3];
    bit          ph[3];
    bit          pl[3];
    bit          pact[3];
    bit          ppwm[3];
    logic [2:0]  exp_hi = '0;
    logic [2:0]  exp_lo = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            rh[c] = 0; rl[c] = 0; ph[c] = 0; pl[c] = 0; pact[c] = 0; ppwm[c] = 0;
        end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            bit act, pd, nh, nl;
            act = m_ctrl[0] && m_ctrl[c+1] && !m_block;
            pd  = pact[c] && !ph[c] && !pl[c];
            nh  = 1'b0;
            nl  = 1'b0;
            if (!act) begin
                rh[c] = 0;
                rl[c] = 0;
            end else if (pwm[c]) begin
                if (rh[c] == 0) cap_h[c] = int'(m_dt_hi);
                rh[c]++;
                rl[c] = 0;
                nh = ph[c] || (rh[c] >= cap_h[c] + 2) || (pd && !ppwm[c]);
            end else begin
                if (rl[c] == 0) cap_l[c] = int'(m_dt_lo);
                rl[c]++;
                rh[c] = 0;
                nl = pl[c] || (rl[c] >= cap_l[c] + 2) || (pd && ppwm[c]);
            end
            ph[c] = nh; pl[c] = nl; pact[c] = act; ppwm[c] = pwm[c];
            exp_hi[c] = nh;
            exp_lo[c] = nl;
        end
        if (bus.cyc && bus.stb && bus.we) begin
            if (bus.adr == c_base && bus.sel[0]) begin
                m_ctrl = bus.dat_m2s[3:0];
                if (bus.dat_m2s[4] && m_allow_clear) m_block = 1'b0;
            end
            if (bus.adr == c_base + 32'h4) begin
                if (bus.sel[0]) m_dt_hi[7:0]  = bus.dat_m2s[7:0];
                if (bus.sel[1]) m_dt_hi[15:8] = bus.dat_m2s[15:8];
                if (bus.sel[2]) m_dt_lo[7:0]  = bus.dat_m2s[23:16];
                if (bus.sel[3]) m_dt_lo[15:8] = bus.dat_m2s[31:24];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("outputs_hi_lo", {26'b0, hi, lo}, {26'b0, exp_hi, exp_lo});
        check("no_overlap", {29'b0, hi & lo}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = adr; bus.dat_m2s = dat; bus.sel = sel;
        #1;
        check("wr_ack", {31'b0, bus.ack}, 32'd1);
        step();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = adr;
        #1;
        check(tag, bus.dat_s2m, exp);
        bus.cyc = 1'b0; bus.stb = 1'b0;
    endtask

    task automatic toggle_random();
        for (int c = 0; c < 3; c++) begin
            if ($urandom_range(5) == 0) pwm[c] = ~pwm[c];
        end
    endtask

    initial begin
        int n;
        int dead;
        rst_n = 1'b0; pwm = '0; fault = 1'b0;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0; bus.dat_m2s = '0; bus.sel = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_outputs", {26'b0, hi, lo}, 32'd0);
        check("idle_ack", {31'b0, bus.ack}, 32'd0);
        check("err_zero", {31'b0, bus.err}, 32'd0);
        wb_read(c_base, 32'd0, "rst_control");
        wb_read(c_base + 32'h4, 32'd0, "rst_deadtime");
        wb_read(c_base + 32'h8, 32'd0, "rst_status");
        step();

        // dt_hi = 3 on ch0: lo falls at E, hi rises after E+4
        wb_write(c_base + 32'h4, 32'h0000_0003, 4'hF);
        wb_write(c_base, 32'h0000_0003, 4'hF);
        repeat (4) step();
        check("ch0_lo_settled", {31'b0, lo[0]}, 32'd1);
        pwm[0] = 1'b1;
        step();
        check("ch0_lo_fall", {31'b0, lo[0]}, 32'd0);
        repeat (3) begin
            step();
            check("ch0_hi_wait", {31'b0, hi[0]}, 32'd0);
        end
        step();
        check("ch0_hi_rise", {31'b0, hi[0]}, 32'd1);

        // zero dead time: every transition shows exactly one both-low cycle
        wb_write(c_base + 32'h4, 32'h0000_0000, 4'hF);
        repeat (2) step();
        dead = 0;
        for (int t = 0; t < 60; t++) begin
            if (t % 10 == 0) pwm[0] = ~pwm[0];
            step();
            if (!hi[0] && !lo[0]) dead++;
        end
        check("dt0_dead_cycles", dead, 32'd6);

        // short pulse on ch1 shorter than dt_hi never reaches the high side
        wb_write(c_base + 32'h4, 32'h0000_0008, 4'hF);
        wb_write(c_base, 32'h0000_0007, 4'hF);
        pwm[1] = 1'b0;
        repeat (4) step();
        check("ch1_lo_settled", {31'b0, lo[1]}, 32'd1);
        pwm[1] = 1'b1;
        repeat (3) begin
            step();
            check("ch1_short_no_hi", {31'b0, hi[1]}, 32'd0);
        end
        pwm[1] = 1'b0;
        step();
        check("ch1_lo_back", {31'b0, lo[1]}, 32'd1);

        // partial DEADTIME write during a running window
        pwm[0] = 1'b0;
        wb_write(c_base + 32'h4, 32'h0007_0006, 4'hF);
        repeat (12) step();
        pwm[0] = 1'b1;
        step();
        step();
        wb_write(c_base + 32'h4, 32'h0005_0002, 4'b0011);
        wb_read(c_base + 32'h4, 32'h0007_0002, "dt_sel_readback");
        n = 2;
        while (hi[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("old_window_len", n, 32'd7);
        pwm[0] = 1'b0;
        repeat (12) step();
        pwm[0] = 1'b1;
        step();
        n = 0;
        while (hi[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("new_window_len", n, 32'd3);

        // unmapped address
        wb_write(c_base + 32'hC, 32'hFFFF_FFFF, 4'hF);
        wb_read(c_base + 32'hC, 32'd0, "unmapped_read");
        wb_read(c_base, 32'h0000_0007, "ctrl_after_unmapped");

        // randomized traffic
        wb_write(c_base, 32'h0000_000F, 4'hF);
        for (int i = 0; i < 500; i++) begin
            toggle_random();
`ifndef PWM_DEADTIME_FAULT_EN
            if (i % 50 == 10) fault = ~fault;
`endif
            if (i % 37 == 5)
                wb_write(c_base + 32'h4, {16'($urandom_range(6)), 16'($urandom_range(6))},
                         4'($urandom_range(1, 15)));
            else if (i % 113 == 50)
                wb_write(c_base, {28'b0, 4'($urandom_range(15)) | 4'b0001}, 4'hF);
            else
                step();
            if (i % 61 == 0)
                wb_read(c_base + 32'h4, {m_dt_lo, m_dt_hi}, "rand_deadtime");
        end
        wb_write(c_base + 32'h4, 32'h0001_0001, 4'hF);
        wb_write(c_base, 32'h0000_000F, 4'hF);
        repeat (20) begin
            toggle_random();
            step();
        end

`ifdef PWM_DEADTIME_FAULT_EN
        fault = 1'b1;
        repeat (3) tick();
        check("fault_outputs_off", {26'b0, hi, lo}, 32'd0);
        wb_read(c_base + 32'h8, 32'h0000_0100, "fault_status");
        model_reset();
        m_block = 1'b1;
        repeat (5) begin
            toggle_random();
            step();
        end
        wb_write(c_base, 32'h0000_001F, 4'h1);
        wb_read(c_base + 32'h8, 32'h0000_0100, "clr_ignored");
        fault = 1'b0;
        repeat (4) step();
        wb_read(c_base + 32'h8, 32'h0000_0100, "latched_after_release");
        m_allow_clear = 1'b1;
        wb_write(c_base, 32'h0000_001F, 4'h1);
        m_allow_clear = 1'b0;
        wb_read(c_base + 32'h8, 32'd0, "clr_status");
        repeat (20) begin
            toggle_random();
            step();
        end
        wb_read(c_base, 32'h0000_000F, "ctrl_clr_reads0");
`else
        fault = 1'b1;
        wb_write(c_base, 32'h0000_001F, 4'hF);
        repeat (3) step();
        wb_read(c_base, 32'h0000_000F, "ctrl_clr_reads0");
        wb_read(c_base + 32'h8, {23'b0, 1'b0, 2'b0, exp_lo, exp_hi}, "status_no_fault");
        fault = 1'b0;
`endif

        // asynchronous reset with ch1 high and ch0 in its high-going dead window
        wb_write(c_base, 32'h0000_0007, 4'hF);
        wb_write(c_base + 32'h4, 32'h0000_000A, 4'hF);
        pwm = 3'b010;
        repeat (15) step();
        check("pre_rst_ch1_hi", {31'b0, hi[1]}, 32'd1);
        pwm[0] = 1'b1;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_hi", {29'b0, hi}, 32'd0);
        check("async_rst_lo", {29'b0, lo}, 32'd0);
        wb_read(c_base, 32'd0, "rst2_control");
        wb_read(c_base + 32'h4, 32'd0, "rst2_deadtime");
        wb_read(c_base + 32'h8, 32'd0, "rst2_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
